bus_transfer_sequencer: RTL and testbench

Sequences register-to-register transfers over the shared 16-bit datapath bus. It accepts queued transfer requests (source code, destination code) through a valid/ready handshake. For each request it drives exactly one one-hot read enable into the bus multiplexer, holds it while the bus settles, then pulses the destination's write enable. It sits directly upstream of the bus multiplexer, between the core controller and the bus; read enables are guaranteed one-hot, so the multiplexer's priority order never matters.

---
 rtl/bus_transfer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// Register-to-register transfer sequencer: queues {src,dst} requests, drives a one-hot
// read enable for SETTLE cycles, then strobes the destination write enable.
module bus_transfer_sequencer #(
  parameter int unsigned NUM_SRC = 10,
  parameter int unsigned NUM_DST = 10,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_src,
  input  logic [3:0]         req_dst,
  output logic [NUM_SRC-1:0] read_en,
  output logic [NUM_DST-1:0] write_en,
  output logic               done,
  output logic [3:0]         done_dst,
  output logic               err,
  output logic               busy
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WRITE} state_t;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [3:0] code);
    return {{(NUM_SRC-1){1'b0}}, 1'b1} << code;
  endfunction

  function automatic logic [NUM_DST-1:0] dst_onehot(input logic [3:0] code);
    return {{(NUM_DST-1){1'b0}}, 1'b1} << code;
  endfunction

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [3:0]       cur_src_q, cur_src_d;
  logic [3:0]       cur_dst_q, cur_dst_d;
  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [NUM_SRC-1:0] read_en_q, read_en_d;
  logic [NUM_DST-1:0] write_en_q, write_en_d;
  logic             done_q, done_d;
  logic [3:0]       done_dst_q, done_dst_d;
  logic             err_q;

  logic             accept, codes_ok, push, pop, fifo_empty;
  logic [3:0]       head_src, head_dst;

  assign req_ready  = (count_q < CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign busy       = !fifo_empty || (state_q != S_IDLE);
  assign accept     = req_valid && req_ready;
  assign codes_ok   = ({28'd0, req_src} < NUM_SRC) && ({28'd0, req_dst} < NUM_DST);
  assign push       = accept && codes_ok;
  assign head_src   = mem_q[rd_ptr_q][7:4];
  assign head_dst   = mem_q[rd_ptr_q][3:0];

  assign read_en  = read_en_q;
  assign write_en = write_en_q;
  assign done     = done_q;
  assign done_dst = done_dst_q;
  assign err      = err_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Outputs are computed from the current state and registered, so they trail the
  // state by one cycle; the WRITE pop therefore chains straight into the next DRIVE.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    pop        = 1'b0;
    read_en_d  = '0;
    write_en_d = '0;
    done_d     = 1'b0;
    done_dst_d = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = S_DRIVE;
          settle_d  = '0;
          cur_src_d = head_src;
          cur_dst_d = head_dst;
        end
      end
      S_DRIVE: begin
        read_en_d = src_onehot(cur_src_q);
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d = S_WRITE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_WRITE: begin
        read_en_d  = src_onehot(cur_src_q);
        write_en_d = dst_onehot(cur_dst_q);
        done_d     = 1'b1;
        done_dst_d = cur_dst_q;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = S_DRIVE;
          settle_d  = '0;
          cur_src_d = head_src;
          cur_dst_d = head_dst;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      read_en_q  <= '0;
      write_en_q <= '0;
      done_q     <= 1'b0;
      done_dst_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      count_q    <= count_d;
      read_en_q  <= read_en_d;
      write_en_q <= write_en_d;
      done_q     <= done_d;
      done_dst_q <= done_dst_d;
      err_q      <= accept && !codes_ok;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_src, req_dst};
    end
    cur_src_q <= cur_src_d;
    cur_dst_q <= cur_dst_d;
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer with a transfer scoreboard checked every cycle.
module tb_bus_transfer_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_ready;
  logic [3:0] req_src, req_dst;
  logic [9:0] read_en, write_en;
  logic       done, err, busy;
  logic [3:0] done_dst;

  logic       r3_valid, r3_ready;
  logic [3:0] r3_src, r3_dst;
  logic [9:0] r3_read_en, r3_write_en;
  logic       r3_done, r3_err, r3_busy;
  logic [3:0] r3_done_dst;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
  } xfer_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    armed = 1'b0;
  xfer_t sb[$];
  int    done_cyc[$];
  int    stall;

  bus_transfer_sequencer #(.NUM_SRC(10), .NUM_DST(10), .DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .read_en(read_en), .write_en(write_en),
    .done(done), .done_dst(done_dst), .err(err), .busy(busy)
  );

  bus_transfer_sequencer #(.NUM_SRC(10), .NUM_DST(10), .DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_src(r3_src), .req_dst(r3_dst), .read_en(r3_read_en), .write_en(r3_write_en),
    .done(r3_done), .done_dst(r3_done_dst), .err(r3_err), .busy(r3_busy)
  );

  function automatic logic [9:0] oh(input logic [3:0] c);
    logic [9:0] v;
    v = '0;
    if (c < 4'd10) v[c] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check invariants and retire completed transfers.
  task automatic tick();
    xfer_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (armed) begin
      check("re_onehot", 32'($countones(read_en) <= 1), 32'd1);
      check("we_onehot", 32'($countones(write_en) <= 1), 32'd1);
      check("we_needs_re", 32'((write_en == '0) || (read_en != '0)), 32'd1);
      check("we_with_done", 32'(write_en != '0), 32'(done));
      check("r3_re_onehot", 32'($countones(r3_read_en) <= 1), 32'd1);
      if (done) begin
        done_cyc.push_back(cyc);
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_done_dst", 32'(done_dst), 32'(e.dst));
          check("sb_write_en", 32'(write_en), 32'(oh(e.dst)));
          check("sb_read_en", 32'(read_en), 32'(oh(e.src)));
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] d, output int stl);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    stl       = 0;
    while (!req_ready && stl < 40) begin
      tick();
      stl++;
    end
    if (!req_ready) check("send_timeout", 32'(req_ready), 32'd1);
    if (s < 4'd10 && d < 4'd10) sb.push_back('{src: s, dst: d});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0;
    r3_valid = 1'b0; r3_src = '0; r3_dst = '0;
    repeat (3) tick();
    check("rst_read_en", 32'(read_en), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_dst", 32'(done_dst), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_r3_read_en", 32'(r3_read_en), 32'd0);
    rst = 1'b0;
    armed = 1'b1;
    tick();

    // Single transfer AC -> 7, accepted at cycle 0
    send(4'd2, 4'd7, stall);
    req_valid = 1'b0;
    check("t1_c0_re", 32'(read_en), 32'd0);
    check("t1_c0_busy", 32'(busy), 32'd1);
    tick();
    check("t1_c1_re", 32'(read_en), 32'd0);
    tick();
    check("t1_c2_re", 32'(read_en), 32'h004);
    check("t1_c2_we", 32'(write_en), 32'd0);
    tick();
    check("t1_c3_re", 32'(read_en), 32'h004);
    check("t1_c3_we", 32'(write_en), 32'h080);
    check("t1_c3_done", 32'(done), 32'd1);
    check("t1_c3_done_dst", 32'(done_dst), 32'd7);
    tick();
    check("t1_c4_re", 32'(read_en), 32'd0);
    check("t1_c4_we", 32'(write_en), 32'd0);
    check("t1_c4_done", 32'(done), 32'd0);
    check("t1_c4_busy", 32'(busy), 32'd0);

    // Invalid codes are consumed and flagged, never sequenced
    send(4'd12, 4'd1, stall);
    req_valid = 1'b0;
    check("inv_src_err", 32'(err), 32'd1);
    check("inv_src_ready", 32'(req_ready), 32'd1);
    check("inv_src_busy", 32'(busy), 32'd0);
    tick();
    check("inv_src_err_pulse", 32'(err), 32'd0);
    send(4'd3, 4'd10, stall);
    req_valid = 1'b0;
    check("inv_dst_err", 32'(err), 32'd1);
    check("inv_dst_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("inv_re", 32'(read_en), 32'd0);
      check("inv_we", 32'(write_en), 32'd0);
      check("inv_err_clear", 32'(err), 32'd0);
    end

    // Burst: FIFO fills, 8th request stalls one cycle while a pop frees a slot
    done_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(4'(i), (i == 4) ? 4'd4 : 4'(9 - i), stall);
      check("burst_stall", 32'(stall), (i == 7) ? 32'd1 : 32'd0);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 60 && (sb.size() != 0 || busy); k++) tick();
    check("burst_drained", 32'(sb.size()), 32'd0);
    check("burst_done_count", 32'(done_cyc.size()), 32'd8);
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("burst_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);
    end

    // SETTLE=3 instance: read_en held 4 cycles, write in the last
    r3_valid = 1'b1; r3_src = 4'd5; r3_dst = 4'd3;
    check("s3_ready", 32'(r3_ready), 32'd1);
    tick();
    r3_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      check("s3_re", 32'(r3_read_en), (c >= 2 && c <= 5) ? 32'(oh(4'd5)) : 32'd0);
      check("s3_we", 32'(r3_write_en), (c == 5) ? 32'(oh(4'd3)) : 32'd0);
      check("s3_done", 32'(r3_done), (c == 5) ? 32'd1 : 32'd0);
      check("s3_done_dst", 32'(r3_done_dst), (c == 5) ? 32'd3 : 32'd0);
      check("s3_err", 32'(r3_err), 32'd0);
      tick();
    end
    check("s3_idle_busy", 32'(r3_busy), 32'd0);

    // Reset while DRIVE with two entries queued
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 6), 4'(i), stall);
    end
    req_valid = 1'b0;
    check("rm_pre_busy", 32'(busy), 32'd1);
    check("rm_pre_sb", 32'(sb.size()), 32'd3);
    rst = 1'b1;
    tick();
    sb.delete();
    check("rm_re", 32'(read_en), 32'd0);
    check("rm_we", 32'(write_en), 32'd0);
    check("rm_done", 32'(done), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rm_post_we", 32'(write_en), 32'd0);
      check("rm_post_re", 32'(read_en), 32'd0);
      check("rm_post_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
